// File: rtl/bram_dp_arbiter_pkg.sv
// Shared constants and helpers for the dual-port BRAM arbiter.
// Read tags are sized for the largest supported requester count.
package bram_arb_pkg;

    localparam int unsigned NUM_REQ_MAX = 8;
    localparam int unsigned RD_LATENCY  = 3;
    localparam int unsigned ID_W_MAX    = $clog2(NUM_REQ_MAX);

    // Width of a requester index / round-robin pointer.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                vld;
        logic [ID_W_MAX-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/bram_dp_arbiter_rr_dual_grant.sv
// Two-grant round-robin picker: first valid requester from the pointer
// gets port A, the second gets port B unless it conflicts with A.
module rr_dual_grant
    import bram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_LINES = 4,
    localparam int unsigned PTR_W     = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]            i_valid,
    input  logic [PTR_W-1:0]              i_ptr,
    input  logic [NUM_REQ*ADDR_LINES-1:0] i_addr,
    input  logic [NUM_REQ-1:0]            i_we,
    output logic [NUM_REQ-1:0]            o_grant_a_c,
    output logic [NUM_REQ-1:0]            o_grant_b_c,
    output logic [PTR_W-1:0]              o_next_ptr_c
);

    logic [ADDR_LINES-1:0] w_addr [NUM_REQ];
    logic                  w_found_a;
    logic                  w_found_b;
    logic                  w_hazard;
    logic [PTR_W-1:0]      w_idx_a;
    logic [PTR_W-1:0]      w_idx_b;
    logic [PTR_W-1:0]      w_scan;
    logic [PTR_W-1:0]      w_last;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign w_addr[g] = i_addr[g*ADDR_LINES +: ADDR_LINES];
    end

    // Circular scan starting at the pointer.
    always_comb begin
        w_found_a = 1'b0;
        w_found_b = 1'b0;
        w_idx_a   = '0;
        w_idx_b   = '0;
        w_scan    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_scan = PTR_W'((32'(i_ptr) + k) % NUM_REQ);
            if (i_valid[w_scan]) begin
                if (!w_found_a) begin
                    w_found_a = 1'b1;
                    w_idx_a   = w_scan;
                end else if (!w_found_b) begin
                    w_found_b = 1'b1;
                    w_idx_b   = w_scan;
                end
            end
        end
    end

    // Same-address pair with a write: B retries, pointer skips only A.
    always_comb begin
        w_hazard     = w_found_b && (w_addr[w_idx_a] == w_addr[w_idx_b])
                       && (i_we[w_idx_a] || i_we[w_idx_b]);
        o_grant_a_c  = '0;
        o_grant_b_c  = '0;
        if (w_found_a) o_grant_a_c[w_idx_a] = 1'b1;
        if (w_found_b && !w_hazard) o_grant_b_c[w_idx_b] = 1'b1;
        w_last       = (w_found_b && !w_hazard) ? w_idx_b : w_idx_a;
        if (!w_found_a) begin
            o_next_ptr_c = i_ptr;
        end else if (w_last == PTR_W'(NUM_REQ - 1)) begin
            o_next_ptr_c = '0;
        end else begin
            o_next_ptr_c = w_last + PTR_W'(1);
        end
    end

endmodule

// File: rtl/bram_dp_arbiter.sv
// Shares one dual-port RAM among NUM_REQ requesters: registers the port
// commands, tracks the fixed read latency and steers read data back.
module bram_dp_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned RAM_WIDTH  = 32,
    parameter int unsigned ADDR_LINES = 4
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_LINES-1:0] req_addr,
    input  logic [NUM_REQ*RAM_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NUM_REQ*RAM_WIDTH-1:0]  rsp_rdata,
    output logic [ADDR_LINES-1:0]         ram_addra,
    output logic [ADDR_LINES-1:0]         ram_addrb,
    output logic [RAM_WIDTH-1:0]          ram_dina,
    output logic [RAM_WIDTH-1:0]          ram_dinb,
    output logic                          ram_wea,
    output logic                          ram_web,
    output logic                          ram_ena,
    output logic                          ram_enb,
    output logic                          ram_regcea,
    output logic                          ram_regceb,
    output logic                          ram_rstna,
    output logic                          ram_rstnb,
    input  logic [RAM_WIDTH-1:0]          ram_douta,
    input  logic [RAM_WIDTH-1:0]          ram_doutb
);

    localparam int unsigned PTR_W = id_width(NUM_REQ);

    logic [PTR_W-1:0]      r_ptr;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    rd_tag_t               r_pa [RD_LATENCY];
    rd_tag_t               r_pb [RD_LATENCY];
    logic [NUM_REQ-1:0]    w_grant_a;
    logic [NUM_REQ-1:0]    w_grant_b;
    logic [PTR_W-1:0]      w_next_ptr;
    logic [PTR_W-1:0]      w_idx_a;
    logic [PTR_W-1:0]      w_idx_b;
    logic                  w_any_a;
    logic                  w_any_b;
    logic [ADDR_LINES-1:0] w_addr  [NUM_REQ];
    logic [RAM_WIDTH-1:0]  w_wdata [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr[g]  = req_addr[g*ADDR_LINES +: ADDR_LINES];
        assign w_wdata[g] = req_wdata[g*RAM_WIDTH +: RAM_WIDTH];
    end

    rr_dual_grant #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_LINES (ADDR_LINES)
    ) u_pick (
        .i_valid      (req_valid),
        .i_ptr        (r_ptr),
        .i_addr       (req_addr),
        .i_we         (req_we),
        .o_grant_a_c  (w_grant_a),
        .o_grant_b_c  (w_grant_b),
        .o_next_ptr_c (w_next_ptr)
    );

    assign req_ready = w_grant_a | w_grant_b;
    assign w_any_a   = |w_grant_a;
    assign w_any_b   = |w_grant_b;
    assign ram_rstna = rstn_i;
    assign ram_rstnb = rstn_i;

    always_comb begin
        w_idx_a = '0;
        w_idx_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant_a[i]) w_idx_a = PTR_W'(i);
            if (w_grant_b[i]) w_idx_b = PTR_W'(i);
        end
    end

    // Port A is enabled for any grant: the RAM gates port B on ena.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ptr       <= '0;
            ram_ena     <= 1'b0;
            ram_enb     <= 1'b0;
            ram_wea     <= 1'b0;
            ram_web     <= 1'b0;
            ram_addra   <= '0;
            ram_addrb   <= '0;
            ram_dina    <= '0;
            ram_dinb    <= '0;
            r_rsp_valid <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                r_pa[s] <= '0;
                r_pb[s] <= '0;
            end
        end else begin
            r_ptr     <= w_next_ptr;
            ram_ena   <= w_any_a || w_any_b;
            ram_enb   <= w_any_b;
            ram_wea   <= w_any_a && req_we[w_idx_a];
            ram_web   <= w_any_b && req_we[w_idx_b];
            ram_addra <= w_any_a ? w_addr[w_idx_a] : w_addr[w_idx_b];
            ram_dina  <= w_wdata[w_idx_a];
            ram_addrb <= w_addr[w_idx_b];
            ram_dinb  <= w_wdata[w_idx_b];
            r_pa[0]   <= '{vld: w_any_a && !req_we[w_idx_a], id: ID_W_MAX'(w_idx_a)};
            r_pb[0]   <= '{vld: w_any_b && !req_we[w_idx_b], id: ID_W_MAX'(w_idx_b)};
            for (int s = 1; s < RD_LATENCY; s++) begin
                r_pa[s] <= r_pa[s-1];
                r_pb[s] <= r_pb[s-1];
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_rsp_valid[i] <= (r_pa[1].vld && (r_pa[1].id == ID_W_MAX'(i)))
                               || (r_pb[1].vld && (r_pb[1].id == ID_W_MAX'(i)));
            end
        end
    end

    assign ram_regcea = r_pa[1].vld;
    assign ram_regceb = r_pb[1].vld;
    assign rsp_valid  = r_rsp_valid;

    // Output-register data goes straight to its requester, no extra stage.
    always_comb begin
        rsp_rdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_pa[2].vld && (r_pa[2].id == ID_W_MAX'(i))) begin
                rsp_rdata[i*RAM_WIDTH +: RAM_WIDTH] = ram_douta;
            end else if (r_pb[2].vld && (r_pb[2].id == ID_W_MAX'(i))) begin
                rsp_rdata[i*RAM_WIDTH +: RAM_WIDTH] = ram_doutb;
            end
        end
    end

endmodule

// File: tb/tb_bram_dp_arbiter.sv
// Bench for bram_dp_arbiter: per-cycle vector table with expected grants,
// a behavioural dual-port RAM and a read-response scoreboard.
module tb_bram_dp_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int AL = 4;
    localparam int K_DUAL = 4;

    logic            clk_i = 1'b0;
    logic            rstn_i;
    logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [N*AL-1:0] req_addr;
    logic [N*W-1:0]  req_wdata, rsp_rdata;
    logic [AL-1:0]   ram_addra, ram_addrb;
    logic [W-1:0]    ram_dina, ram_dinb;
    logic            ram_wea, ram_web, ram_ena, ram_enb;
    logic            ram_regcea, ram_regceb, ram_rstna, ram_rstnb;
    logic [W-1:0]    ram_douta = '0;
    logic [W-1:0]    ram_doutb = '0;

    always #5 clk_i = ~clk_i;

    bram_dp_arbiter #(.NUM_REQ(N), .RAM_WIDTH(W), .ADDR_LINES(AL)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_addra(ram_addra), .ram_addrb(ram_addrb),
        .ram_dina(ram_dina), .ram_dinb(ram_dinb),
        .ram_wea(ram_wea), .ram_web(ram_web), .ram_ena(ram_ena), .ram_enb(ram_enb),
        .ram_regcea(ram_regcea), .ram_regceb(ram_regceb),
        .ram_rstna(ram_rstna), .ram_rstnb(ram_rstnb),
        .ram_douta(ram_douta), .ram_doutb(ram_doutb)
    );

    // Dual-port RAM: array read when enabled, output register on regce.
    logic [W-1:0] mem [16];
    logic [W-1:0] ram_data_a = '0;
    logic [W-1:0] ram_data_b = '0;
    initial for (int i = 0; i < 16; i++) mem[i] = '0;

    always @(posedge clk_i) begin
        if (ram_ena) begin
            if (ram_wea) mem[ram_addra] <= ram_dina;
            ram_data_a <= mem[ram_addra];
        end
        if (ram_ena && ram_enb) begin
            if (ram_web) mem[ram_addrb] <= ram_dinb;
            ram_data_b <= mem[ram_addrb];
        end
        if (!ram_rstna) ram_douta <= '0;
        else if (ram_regcea) ram_douta <= ram_data_a;
        if (!ram_rstnb) ram_doutb <= '0;
        else if (ram_regceb) ram_doutb <= ram_data_b;
    end

    typedef struct packed {
        logic                rst;
        logic [N-1:0]        valid;
        logic [N-1:0]        we;
        logic [N-1:0][AL-1:0] addr;
        logic [N-1:0][W-1:0] wdata;
        logic [N-1:0]        exp_ready;
    } vec_t;

    typedef struct {
        int          due;
        int          id;
        logic [W-1:0] data;
    } exp_t;

    vec_t         tbl[$];
    exp_t         sb[$];
    logic [W-1:0] model_mem [16];
    int           vectors = 0;
    int           miscompares = 0;

    function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] we,
                                input logic [3:0] a0, input logic [3:0] a1,
                                input logic [3:0] a2, input logic [3:0] a3,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [3:0] rdy);
        vec_t v;
        v.rst = 1'b0;
        v.valid = valid;
        v.we = we;
        v.addr = {a3, a2, a1, a0};
        v.wdata = {d3, d2, d1, d0};
        v.exp_ready = rdy;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h want %0h", name, $time, got, want);
        end
    endtask

    // Port B must never be enabled without port A.
    always @(negedge clk_i) begin
        if (rstn_i === 1'b1) begin
            assert (!(ram_enb && !ram_ena))
            else begin
                miscompares++;
                $display("FAIL enb_without_ena @%0t: ena=%b enb=%b", $time, ram_ena, ram_enb);
            end
        end
    end

    initial begin
        vec_t         v;
        exp_t         e;
        logic [N-1:0] exp_v;
        logic [1:0]   en_exp;
        vec_t         rv;

        // Preload, single read, dual read, hazard, fairness, port-B, single requester.
        tbl.push_back(mk(4'b0011, 4'b0011, 3, 5, 0, 0, 32'hDEADBEEF, 32'h55, 0, 0, 4'b0011));
        tbl.push_back(mk(4'b0100, 4'b0100, 0, 0, 9, 0, 0, 0, 32'h99, 0, 4'b0100));
        tbl.push_back(idle());
        tbl.push_back(mk(4'b0001, 4'b0000, 3, 0, 0, 0, 0, 0, 0, 0, 4'b0001));
        tbl.push_back(mk(4'b0110, 4'b0000, 0, 5, 9, 0, 0, 0, 0, 0, 4'b0110));
        tbl.push_back(mk(4'b0011, 4'b0001, 7, 7, 0, 0, 32'h11, 0, 0, 0, 4'b0001));
        tbl.push_back(mk(4'b0010, 4'b0000, 0, 7, 0, 0, 0, 0, 0, 0, 4'b0010));
        for (int r = 0; r < 4; r++)
            tbl.push_back(mk(4'b1111, 4'b0000, 3, 5, 9, 7, 0, 0, 0, 0, (r % 2 == 0) ? 4'b1100 : 4'b0011));
        tbl.push_back(mk(4'b1100, 4'b0000, 0, 0, 9, 7, 0, 0, 0, 0, 4'b1100));
        tbl.push_back(mk(4'b1001, 4'b0000, 3, 0, 0, 7, 0, 0, 0, 0, 4'b1001));
        tbl.push_back(mk(4'b1001, 4'b0000, 3, 0, 0, 7, 0, 0, 0, 0, 4'b1001));
        tbl.push_back(mk(4'b1000, 4'b0000, 0, 0, 0, 3, 0, 0, 0, 0, 4'b1000));
        tbl.push_back(mk(4'b1000, 4'b0000, 0, 0, 0, 5, 0, 0, 0, 0, 4'b1000));
        tbl.push_back(mk(4'b1000, 4'b0000, 0, 0, 0, 9, 0, 0, 0, 0, 4'b1000));
        // Writes on both ports, boundary addresses, write-write hazard, read-read same address.
        tbl.push_back(mk(4'b0110, 4'b0110, 0, 2, 15, 0, 0, 32'hA5A5A5A5, 32'h0F0F0F0F, 0, 4'b0110));
        tbl.push_back(mk(4'b1001, 4'b0000, 2, 0, 0, 15, 0, 0, 0, 0, 4'b1001));
        tbl.push_back(mk(4'b0110, 4'b0110, 0, 0, 0, 0, 0, 32'h1, 32'h2, 0, 4'b0010));
        tbl.push_back(mk(4'b0100, 4'b0100, 0, 0, 0, 0, 0, 0, 32'h2, 0, 4'b0100));
        tbl.push_back(mk(4'b0001, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001));
        tbl.push_back(mk(4'b0011, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0011));
        for (int r = 0; r < 4; r++) tbl.push_back(idle());
        // Reset one cycle after accepting a read; pointer must restart at 0.
        tbl.push_back(mk(4'b0001, 4'b0000, 3, 0, 0, 0, 0, 0, 0, 0, 4'b0001));
        rv = idle();
        rv.rst = 1'b1;
        tbl.push_back(rv);
        tbl.push_back(mk(4'b1111, 4'b0000, 3, 5, 9, 7, 0, 0, 0, 0, 4'b0011));
        tbl.push_back(mk(4'b1111, 4'b0000, 3, 5, 9, 7, 0, 0, 0, 0, 4'b1100));
        for (int r = 0; r < 5; r++) tbl.push_back(idle());

        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        rstn_i = 1'b0;
        req_valid = '0;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_ready", 128'(req_ready), 128'(0));
        chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("reset_rsp_rdata", 128'(rsp_rdata), 128'(0));
        chk("reset_ram_ctrl", 128'({ram_ena, ram_enb, ram_wea, ram_web, ram_regcea, ram_regceb, ram_rstna, ram_rstnb}), 128'(0));

        en_exp = 2'b00;
        for (int k = 0; k < tbl.size(); k++) begin
            @(posedge clk_i);
            #1;
            v = tbl[k];
            rstn_i    = !v.rst;
            req_valid = v.valid;
            req_we    = v.we;
            req_addr  = v.addr;
            req_wdata = v.wdata;
            if (v.rst) begin
                sb.delete();
                en_exp = 2'b00;
            end
            @(negedge clk_i);
            chk($sformatf("ready[%0d]", k), 128'(req_ready), 128'(v.exp_ready));
            chk($sformatf("ena_enb[%0d]", k), 128'({ram_ena, ram_enb}), 128'(en_exp));
            exp_v = '0;
            while (sb.size() > 0 && sb[0].due == k) begin
                e = sb.pop_front();
                exp_v[e.id] = 1'b1;
                chk($sformatf("rdata[%0d] req%0d", k, e.id), 128'(rsp_rdata[e.id*W +: W]), 128'(e.data));
            end
            chk($sformatf("rsp_valid[%0d]", k), 128'(rsp_valid), 128'(exp_v));
            if (k == K_DUAL + 2)
                chk("dual_regce", 128'({ram_regcea, ram_regceb}), 128'(2'b11));
            if (v.rst) begin
                chk("midrst_ram_cmd", 128'({ram_addra, ram_addrb, ram_dina, ram_dinb}), 128'(0));
                chk("midrst_ram_ctrl", 128'({ram_ena, ram_enb, ram_wea, ram_web, ram_regcea, ram_regceb}), 128'(0));
                chk("midrst_rsp", 128'({rsp_valid, rsp_rdata}), 128'(0));
            end
            for (int i = 0; i < N; i++)
                if (v.exp_ready[i] && !v.we[i])
                    sb.push_back('{due: k + 3, id: i, data: model_mem[v.addr[i]]});
            for (int i = 0; i < N; i++)
                if (v.exp_ready[i] && v.we[i]) model_mem[v.addr[i]] = v.wdata[i];
            en_exp = v.rst ? 2'b00 : {|v.exp_ready, $countones(v.exp_ready) == 2};
        end
        chk("scoreboard_drained", 128'(sb.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
